// File: rtl/axi_line_fill.sv
// Read-only AXI4 burst master: fetches one BEATS x 32-bit cache line and returns it as one wide word.
// Optional macro AXI_FILL_CRITICAL_WORD_EN selects a WRAP burst that returns the missed word first.
module axi_line_fill #(
  parameter int ADDR_W = 32,
  parameter int BEATS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  output logic                  resp_valid,
  output logic [BEATS*32-1:0]   resp_line,
  output logic                  resp_err,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_W-1:0]     araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic                  rlast
);

  localparam int CW = $clog2(BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] araddr_reg;
  logic [CW-1:0]     start_word_reg;
  logic [CW-1:0]     cnt_reg;
  logic              err_reg;
  logic [31:0]       words_reg [BEATS];

  logic [ADDR_W-1:0] araddr_next;
  logic [CW-1:0]     start_word_next;
  logic [CW-1:0]     slot;
  logic              beat;

`ifdef AXI_FILL_CRITICAL_WORD_EN
  assign araddr_next     = req_addr & ~ADDR_W'(3);
  assign start_word_next = req_addr[CW+1:2];
  assign arburst         = 2'b10;
`else
  assign araddr_next     = req_addr & ~ADDR_W'((1 << (CW + 2)) - 1);
  assign start_word_next = '0;
  assign arburst         = 2'b01;
`endif

  // Slot index wraps modulo BEATS through the natural CW-bit truncation.
  assign slot = start_word_reg + cnt_reg;
  assign beat = (state_reg == S_R) && rvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      araddr_reg     <= '0;
      start_word_reg <= '0;
      cnt_reg        <= '0;
      err_reg        <= 1'b0;
      for (int i = 0; i < BEATS; i++) words_reg[i] <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            araddr_reg     <= araddr_next;
            start_word_reg <= start_word_next;
            cnt_reg        <= '0;
            err_reg        <= 1'b0;
            state_reg      <= S_AR;
          end
        end
        S_AR: begin
          if (arready) state_reg <= S_R;
        end
        S_R: begin
          if (beat) begin
            words_reg[slot] <= rdata;
            cnt_reg         <= cnt_reg + 1'b1;
            // Early or missing rlast is flagged, but the beat count alone ends the burst.
            if ((rresp != 2'b00) || (rlast != (cnt_reg == LAST_BEAT))) err_reg <= 1'b1;
            if (cnt_reg == LAST_BEAT) state_reg <= S_DONE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_reg == S_IDLE);
  assign arvalid    = (state_reg == S_AR);
  assign rready     = (state_reg == S_R);
  assign resp_valid = (state_reg == S_DONE);
  assign resp_err   = (state_reg == S_DONE) && err_reg;
  assign araddr     = araddr_reg;
  assign arlen      = 8'(BEATS - 1);
  assign arsize     = 3'b010;

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_pack
      assign resp_line[gi*32 +: 32] = words_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_axi_line_fill.sv
// Directed bench for axi_line_fill (BEATS=4) with a procedural AXI read slave.
// Expectations follow whichever build AXI_FILL_CRITICAL_WORD_EN selects.
module tb_axi_line_fill;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         resp_valid;
  logic [127:0] resp_line;
  logic         resp_err;
  logic         arvalid;
  logic         arready;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic         rlast;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;
  logic [31:0] mem [16];

`ifdef AXI_FILL_CRITICAL_WORD_EN
  localparam logic [1:0] EXP_BURST = 2'b10;
`else
  localparam logic [1:0] EXP_BURST = 2'b01;
`endif

  axi_line_fill #(.ADDR_W(32), .BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_line(resp_line), .resp_err(resp_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready), .rlast(rlast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (resp_valid) pulses++;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts and ends at a falling edge with the DUT in IDLE.
  task automatic fill(input logic [31:0] addr, input logic [127:0] exp_line,
                      input int ar_stall, input logic [3:0] gaps, input int err_beat,
                      input int last_beat, input logic exp_err, input logic hold,
                      input int abort_after);
    logic [31:0] exp_araddr;
    int s, b, cycles;
`ifdef AXI_FILL_CRITICAL_WORD_EN
    exp_araddr = addr & ~32'h3;
    s = int'(addr[3:2]);
`else
    exp_araddr = addr & ~32'hF;
    s = 0;
`endif
    b = int'(addr[5:4]) * 4;
    req_valid = 1'b1;
    req_addr  = addr;
    check_eq("req_ready_idle", 128'(req_ready), 128'(1'b1));
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    check_eq("arvalid", 128'(arvalid), 128'(1'b1));
    check_eq("req_ready_busy", 128'(req_ready), 128'(1'b0));
    check_eq("arlen", 128'(arlen), 128'(8'd3));
    check_eq("arsize", 128'(arsize), 128'(3'd2));
    check_eq("arburst", 128'(arburst), 128'(EXP_BURST));
    repeat (ar_stall) begin
      @(negedge clk);
      check_eq("araddr_stall", 128'(araddr), 128'(exp_araddr));
      check_eq("arvalid_stall", 128'(arvalid), 128'(1'b1));
    end
    check_eq("araddr", 128'(araddr), 128'(exp_araddr));
    arready = 1'b1;
    cycles = 0;
    @(negedge clk);
    arready = 1'b0;
    cycles++;
    for (int k = 0; k < 4; k++) begin
      if (k == abort_after) begin
        rst = 1'b1;
        rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_req_ready", 128'(req_ready), 128'(1'b1));
        check_eq("abort_rready", 128'(rready), 128'(1'b0));
        check_eq("abort_arvalid", 128'(arvalid), 128'(1'b0));
        check_eq("abort_resp_valid", 128'(resp_valid), 128'(1'b0));
        check_eq("abort_resp_line", resp_line, 128'h0);
        repeat (3) @(negedge clk);
        $display("fill addr=%h aborted after %0d beats", addr, k);
        return;
      end
      if (gaps[k]) begin
        rvalid = 1'b0;
        repeat (2) begin @(negedge clk); cycles++; end
      end
      check_eq("rready", 128'(rready), 128'(1'b1));
      rvalid = 1'b1;
      rdata  = mem[b + ((s + k) % 4)];
      rresp  = (k == err_beat) ? 2'b10 : 2'b00;
      rlast  = (k == last_beat);
      @(negedge clk);
      cycles++;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    check_eq("resp_valid", 128'(resp_valid), 128'(1'b1));
    check_eq("resp_err", 128'(resp_err), 128'(exp_err));
    check_eq("resp_line", resp_line, exp_line);
    check_eq("req_ready_done", 128'(req_ready), 128'(1'b0));
    if (ar_stall == 0 && gaps == 4'b0) check_eq("latency", 128'(cycles), 128'(5));
    $display("fill addr=%h araddr=%h line=%h err=%0d", addr, araddr, resp_line, resp_err);
    @(negedge clk);
    check_eq("resp_valid_drop", 128'(resp_valid), 128'(1'b0));
    check_eq("req_ready_back", 128'(req_ready), 128'(1'b1));
  endtask

  localparam logic [127:0] LINE0 = 128'h00000044_00000033_00000022_00000011;
  localparam logic [127:0] LINE1 = 128'hA0A0001C_A0A00018_A0A00014_A0A00010;
  localparam logic [127:0] LINE2 = 128'hC0DE002C_C0DE0028_C0DE0024_C0DE0020;
  localparam logic [127:0] LINE3 = 128'h5050003C_50500038_50500034_50500030;

  initial begin
    int p0;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    for (int i = 0; i < 4; i++) begin
      mem[4 + i]  = 32'hA0A0_0010 + 32'(4 * i);
      mem[8 + i]  = 32'hC0DE_0020 + 32'(4 * i);
      mem[12 + i] = 32'h5050_0030 + 32'(4 * i);
    end
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; arready = 1'b0;
    rdata = '0; rresp = 2'b00; rvalid = 1'b0; rlast = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", 128'(req_ready), 128'(1'b1));
    check_eq("rst_arvalid", 128'(arvalid), 128'(1'b0));
    check_eq("rst_rready", 128'(rready), 128'(1'b0));
    check_eq("rst_resp_valid", 128'(resp_valid), 128'(1'b0));
    check_eq("rst_resp_err", 128'(resp_err), 128'(1'b0));
    check_eq("rst_resp_line", resp_line, 128'h0);
    check_eq("rst_araddr", 128'(araddr), 128'h0);
    rst = 1'b0;

    fill(32'h8000_0000, LINE0, 0, 4'b0000, -1, 3, 1'b0, 1'b0, -1);
    fill(32'h8000_0018, LINE1, 0, 4'b0000, -1, 3, 1'b0, 1'b0, -1);
    fill(32'h8000_0024, LINE2, 7, 4'b1011, -1, 3, 1'b0, 1'b0, -1);
    fill(32'h8000_0030, LINE3, 0, 4'b0000,  2, 3, 1'b1, 1'b0, -1);
    fill(32'h8000_0030, LINE3, 0, 4'b0000, -1, 1, 1'b1, 1'b0, -1);

    p0 = pulses;
    fill(32'h8000_0020, LINE2, 0, 4'b0000, -1, 3, 1'b0, 1'b0, 2);
    check_eq("abort_no_pulse", 128'(pulses - p0), 128'(0));
    fill(32'h8000_0000, LINE0, 0, 4'b0000, -1, 3, 1'b0, 1'b0, -1);

    p0 = pulses;
    fill(32'h8000_0000, LINE0, 0, 4'b0000, -1, 3, 1'b0, 1'b1, -1);
    fill(32'h8000_0010, LINE1, 0, 4'b0000, -1, 3, 1'b0, 1'b1, -1);
    fill(32'h8000_0020, LINE2, 0, 4'b0000, -1, 3, 1'b0, 1'b1, -1);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("hold_pulses", 128'(pulses - p0), 128'(3));
    check_eq("hold_idle", 128'(req_ready), 128'(1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_line_fill.md
# axi_line_fill

Read-only AXI4 burst master that fetches one cache line from the block-memory AXI slave (blk_mem_gen) and returns it as a single wide word. It sits between the CPU-side cache miss logic in Top and the memory's s_axi read channels. It issues one BEATS-beat, 32-bit-per-beat burst per request and assembles the beats into a line. Write channels are not driven by this block.

## Interface
- ADDR_W, 32, byte-address width.
- BEATS, 4, beats per line; power of two, 2..16; line = BEATS*32 bits.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  line-fill request.
- req_ready  out  1  high only in IDLE.
- req_addr  in  ADDR_W  byte address of the missing word.
- resp_valid  out  1  one-cycle pulse: line complete.
- resp_line  out  BEATS*32  line, word 0 in bits [31:0], natural address order.
- resp_err  out  1  valid with resp_valid; any RRESP≠0 or RLAST protocol error.
- arvalid / arready  out / in  1  AR handshake.
- araddr  out  ADDR_W  burst start address.
- arlen  out  8  constant BEATS-1.
- arsize  out  3  constant 3'b010.
- arburst  out  2  2'b01 INCR, or 2'b10 WRAP (see Configuration).
- rdata  in  32  read data.
- rresp  in  2  read response.
- rvalid / rready  in / out  1  R handshake.
- rlast  in  1  last beat marker.

## Operation
- FSM states: IDLE, AR, R, DONE.
- IDLE: req_ready=1. On req_valid, latch the address and go to AR. Clear the beat counter and the error flag.
- AR: arvalid=1. araddr is held stable until arready. On arvalid&&arready, go to R.
- R: rready=1. Each rvalid&&rready beat writes rdata into word slot (start_word+cnt) mod BEATS, then cnt increments.
  - rresp≠2'b00 on any beat sets the sticky error flag.
  - rlast=1 on a beat with cnt<BEATS-1 sets the error flag; the FSM still waits for BEATS beats.
  - rlast=0 on the beat with cnt=BEATS-1 sets the error flag.
  - Go to DONE after beat BEATS-1.
- DONE: resp_valid=1 and resp_err=flag for exactly one cycle, then go to IDLE.
- Counter width is log2(BEATS). Slot index wraps modulo BEATS.
- resp_line holds its value until beats of the next burst overwrite it.
- No ordering with writes; one outstanding burst maximum.

## Timing
- Reset values: state IDLE, req_ready=1, arvalid=0, rready=0, resp_valid=0, resp_err=0, resp_line=0, araddr=0.
- Reset mid-operation returns to IDLE on the next edge and drops arvalid/rready. The slave shares rst and is reset in the same cycle.
- The request is accepted on edge T. arvalid is high from T+1.
- If arready is high at T+1 and rvalid streams continuously, beats land in T+2..T+1+BEATS, resp_valid is high in cycle T+2+BEATS, and req_ready returns at T+3+BEATS. Minimum turnaround is BEATS+3 cycles.
- arready stalls extend AR. rvalid gaps extend R. No timeout.
- req_valid during a busy state is ignored because req_ready=0.
- Outputs are registered. No combinational path from AXI inputs to AXI outputs.

## Configuration
- AXI_FILL_CRITICAL_WORD_EN
  - Defined:
    - arburst=2'b10 (WRAP).
    - araddr=req_addr with bits[1:0] cleared.
    - start_word=req_addr[log2(BEATS)+1:2].
    - The first beat returned is the missed word.
  - Undefined:
    - arburst=2'b01 (INCR).
    - araddr=req_addr with the low log2(BEATS)+2 bits cleared.
    - start_word=0.
  - resp_line ordering is identical in both builds.

## Test plan
- Reset, then req_addr=32'h8000_0000, memory words 0x11,0x22,0x33,0x44 -> araddr=32'h8000_0000, arlen=3, arsize=2, resp_line=128'h44_..._33_..._22_..._11 (one 32-bit word each), resp_err=0, resp_valid exactly 5 cycles after arready with back-to-back beats.
- req_addr=32'h8000_0018 with macro defined, words at 0x10..0x1C = A,B,C,D -> araddr=32'h8000_0018, arburst=2'b10, beats C,D,A,B, resp_line={D,C,B,A}. Without the macro -> araddr=32'h8000_0010, arburst=2'b01.
- arready held low 7 cycles and random rvalid gaps -> araddr stable throughout, no beat lost, correct line.
- rresp=2'b10 on beat 2 -> resp_err=1 with resp_valid. rlast asserted on beat 1 -> resp_err=1, four beats still consumed.
- rst=1 during R after 2 beats -> next cycle IDLE, rready=0, resp_valid never pulses. A new request completes normally.
- req_valid held high continuously over 3 fills -> exactly 3 resp_valid pulses, req_ready low from acceptance until after each DONE cycle.
